idu_pipe_stage: RTL and testbench

- Parametrised successor to the combinational RV32 instruction decoder.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and decodes them to immediates, register indices, a one-hot ALU op and a packed control bundle.
- Registers the result into a 2-entry skid-buffered pipeline stage between IFU and EXU.
- Adds RV32E/RV32I register-width selection, optional M-extension decode, illegal-instruction detection, and flush.

---
 rtl/idu_pipe_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_idu_pipe_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe_stage.sv
// RV32 decode stage: combinational decoder feeding a registered main entry plus one skid entry.
// Handshake is valid/ready on both sides; flush drops everything held and anything presented.
module idu_pipe_stage #(
  parameter int unsigned REG_AW = 4,
  parameter bit          EN_M   = 1'b0,
  parameter int unsigned ALU_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ins,
  input  logic [31:0]       in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [11:0]       out_csr_addr,
  output logic [2:0]        out_exu_opt,
  output logic [ALU_W-1:0]  out_alu_opt,
  output logic [1:0]        out_src_sel1,
  output logic [2:0]        out_src_sel2,
  output logic [11:0]       out_ctrl,
  output logic              out_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [ALU_W-1:0] AluAdd  = ALU_W'(1 << 0);
  localparam logic [ALU_W-1:0] AluSub  = ALU_W'(1 << 1);
  localparam logic [ALU_W-1:0] AluSll  = ALU_W'(1 << 2);
  localparam logic [ALU_W-1:0] AluSlt  = ALU_W'(1 << 3);
  localparam logic [ALU_W-1:0] AluSltu = ALU_W'(1 << 4);
  localparam logic [ALU_W-1:0] AluXor  = ALU_W'(1 << 5);
  localparam logic [ALU_W-1:0] AluSrl  = ALU_W'(1 << 6);
  localparam logic [ALU_W-1:0] AluOr   = ALU_W'(1 << 7);
  localparam logic [ALU_W-1:0] AluAnd  = ALU_W'(1 << 8);
  localparam logic [ALU_W-1:0] AluSra  = ALU_W'(1 << 9);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [11:0]       csr_addr;
    logic [2:0]        exu_opt;
    logic [ALU_W-1:0]  alu_opt;
    logic [1:0]        src_sel1;
    logic [2:0]        src_sel2;
    logic [11:0]       ctrl;
    logic              illegal;
  } entry_t;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_opr, w_fence, w_sys;
  logic w_use_rd, w_use_rs1, w_use_rs2, w_known, w_f7_ok, w_reg_bad, w_illegal;
  logic [ALU_W-1:0] w_alu;
  entry_t w_dec;

  assign w_op    = in_ins[6:0];
  assign w_f3    = in_ins[14:12];
  assign w_f7    = in_ins[31:25];
  assign w_lui   = (w_op == OpLui);
  assign w_auipc = (w_op == OpAuipc);
  assign w_jal   = (w_op == OpJal);
  assign w_jalr  = (w_op == OpJalr);
  assign w_br    = (w_op == OpBranch);
  assign w_ld    = (w_op == OpLoad);
  assign w_st    = (w_op == OpStore);
  assign w_opi   = (w_op == OpImm);
  assign w_opr   = (w_op == OpReg);
  assign w_fence = (w_op == OpFence);
  assign w_sys   = (w_op == OpSystem);

  assign w_known = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_opr |
                   w_fence | w_sys;
  assign w_use_rd  = w_lui | w_auipc | w_jal | w_jalr | w_ld | w_opi | w_opr | w_sys;
  assign w_use_rs1 = w_jalr | w_br | w_ld | w_st | w_opi | w_opr | w_sys;
  assign w_use_rs2 = w_opr | w_br | w_st;

  assign w_f7_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000) ||
                   (EN_M && (w_f7 == 7'b0000001));
  // RV32E only has x0..x15: bit 4 of any used register field is illegal.
  assign w_reg_bad = (REG_AW < 5) && ((w_use_rd && in_ins[11]) || (w_use_rs1 && in_ins[19]) ||
                                      (w_use_rs2 && in_ins[24]));
  assign w_illegal = !w_known || (w_opr && !w_f7_ok) || w_reg_bad;

  always_comb begin
    w_alu = '0;
    if (w_ld || w_st || w_lui || w_auipc || w_jal || w_jalr) begin
      w_alu = AluAdd;
    end else if (w_opr || w_opi) begin
      unique case (w_f3)
        3'b000:  w_alu = (w_opr && in_ins[30]) ? AluSub : AluAdd;
        3'b001:  w_alu = AluSll;
        3'b010:  w_alu = AluSlt;
        3'b011:  w_alu = AluSltu;
        3'b100:  w_alu = AluXor;
        3'b101:  w_alu = in_ins[30] ? AluSra : AluSrl;
        3'b110:  w_alu = AluOr;
        default: w_alu = AluAnd;
      endcase
    end else if (w_br) begin
      unique case (w_f3[2:1])
        2'b00:   w_alu = AluSub;
        2'b10:   w_alu = AluSlt;
        2'b11:   w_alu = AluSltu;
        default: w_alu = '0;
      endcase
    end else if (w_sys) begin
      if (w_f3 == 3'b001) w_alu = AluAdd;
      else if (w_f3 == 3'b010) w_alu = AluOr;
    end
  end

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.exu_opt = w_f3;
    w_dec.illegal = w_illegal;

    if (w_ld || w_opi || w_jalr) begin
      w_dec.imm = {{20{in_ins[31]}}, in_ins[31:20]};
    end else if (w_lui || w_auipc) begin
      w_dec.imm = {in_ins[31:12], 12'b0};
    end else if (w_jal) begin
      w_dec.imm = {{12{in_ins[31]}}, in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
    end else if (w_br) begin
      w_dec.imm = {{20{in_ins[31]}}, in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
    end else if (w_st) begin
      w_dec.imm = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
    end

    w_dec.rd       = w_use_rd  ? in_ins[7 +: REG_AW]  : '0;
    w_dec.rs1      = w_use_rs1 ? in_ins[15 +: REG_AW] : '0;
    w_dec.rs2      = w_use_rs2 ? in_ins[20 +: REG_AW] : '0;
    w_dec.csr_addr = w_sys ? in_ins[31:20] : 12'h000;

    w_dec.src_sel1 = (w_auipc || w_jal || w_jalr) ? 2'b10 : 2'b01;
    if (w_opr || w_br || (w_sys && (w_f3 == 3'b010))) w_dec.src_sel2 = 3'b001;
    else if (w_jal || w_jalr)                          w_dec.src_sel2 = 3'b100;
    else                                               w_dec.src_sel2 = 3'b010;

    if (!w_illegal) begin
      w_dec.alu_opt  = w_alu;
      w_dec.ctrl[0]  = w_ld;
      w_dec.ctrl[1]  = w_st;
      w_dec.ctrl[2]  = w_br;
      w_dec.ctrl[3]  = w_jal;
      w_dec.ctrl[4]  = w_jalr;
      w_dec.ctrl[5]  = w_sys && (w_f3 == 3'b000) && (in_ins[21:20] == 2'b00);
      w_dec.ctrl[6]  = w_sys && (w_f3 == 3'b000) && (in_ins[21:20] == 2'b01);
      w_dec.ctrl[7]  = w_sys && (w_f3 == 3'b000) && (in_ins[21:20] == 2'b10);
      w_dec.ctrl[8]  = w_fence && (w_f3 == 3'b001);
      w_dec.ctrl[9]  = EN_M && w_opr && (w_f7 == 7'b0000001);
      w_dec.ctrl[10] = !(w_st || w_br || w_fence);
      w_dec.ctrl[11] = w_sys && (w_f3 != 3'b000);
    end
  end

  entry_t r_main, r_skid;
  logic   r_valid, r_skid_valid, r_in_ready;
  logic   w_accept;

  assign w_accept = in_valid && r_in_ready && !flush;

  // r_in_ready always mirrors !r_skid_valid, so an accept never coincides with a full skid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_valid || out_ready) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else begin
        r_valid <= w_accept;
        if (w_accept) r_main <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_valid;
  assign out_pc       = r_main.pc;
  assign out_imm      = r_main.imm;
  assign out_rd       = r_main.rd;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_csr_addr = r_main.csr_addr;
  assign out_exu_opt  = r_main.exu_opt;
  assign out_alu_opt  = r_main.alu_opt;
  assign out_src_sel1 = r_main.src_sel1;
  assign out_src_sel2 = r_main.src_sel2;
  assign out_ctrl     = r_main.ctrl;
  assign out_illegal  = r_main.illegal;

endmodule

// File: tb/tb_idu_pipe_stage.sv
// Bench for idu_pipe_stage: an RV32E/no-M and an RV32I/M instance share stimulus and are
// compared every cycle against a queue-based pipeline model and an instruction-level decoder.
module tb_idu_pipe_stage;

  logic clock = 1'b0;
  logic reset;
  logic in_valid, flush, out_ready;
  logic [31:0] in_ins, in_pc;

  always #5 clock = ~clock;

  logic e_in_ready, e_out_valid, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [3:0] e_rd, e_rs1, e_rs2;
  logic [11:0] e_csr, e_ctrl;
  logic [2:0] e_f3, e_s2;
  logic [9:0] e_alu;
  logic [1:0] e_s1;

  logic i_in_ready, i_out_valid, i_illegal;
  logic [31:0] i_pc, i_imm;
  logic [4:0] i_rd, i_rs1, i_rs2;
  logic [11:0] i_csr, i_ctrl;
  logic [2:0] i_f3, i_s2;
  logic [9:0] i_alu;
  logic [1:0] i_s1;

  idu_pipe_stage #(.REG_AW(4), .EN_M(1'b0), .ALU_W(10)) dut_e (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(e_out_valid),
    .out_ready(out_ready), .out_pc(e_pc), .out_imm(e_imm), .out_rd(e_rd), .out_rs1(e_rs1),
    .out_rs2(e_rs2), .out_csr_addr(e_csr), .out_exu_opt(e_f3), .out_alu_opt(e_alu),
    .out_src_sel1(e_s1), .out_src_sel2(e_s2), .out_ctrl(e_ctrl), .out_illegal(e_illegal)
  );

  idu_pipe_stage #(.REG_AW(5), .EN_M(1'b1), .ALU_W(10)) dut_i (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(i_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(i_out_valid),
    .out_ready(out_ready), .out_pc(i_pc), .out_imm(i_imm), .out_rd(i_rd), .out_rs1(i_rs1),
    .out_rs2(i_rs2), .out_csr_addr(i_csr), .out_exu_opt(i_f3), .out_alu_opt(i_alu),
    .out_src_sel1(i_s1), .out_src_sel2(i_s2), .out_ctrl(i_ctrl), .out_illegal(i_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] csr;
    logic [2:0]  f3;
    logic [9:0]  alu;
    logic [1:0]  s1;
    logic [2:0]  s2;
    logic [11:0] ctrl;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } txn_t;

  txn_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level reference: what each RV32 class means, not how the stage builds it.
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input int aw, input bit em);
    exp_t d;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit lui = (op == 7'h37), auipc = (op == 7'h17), jal = (op == 7'h6f), jalr = (op == 7'h67);
    bit br = (op == 7'h63), ld = (op == 7'h03), st = (op == 7'h23), opi = (op == 7'h13);
    bit opr = (op == 7'h33), fen = (op == 7'h0f), sys = (op == 7'h73);
    bit urd = lui | auipc | jal | jalr | ld | opi | opr | sys;
    bit urs1 = jalr | br | ld | st | opi | opr | sys;
    bit urs2 = opr | br | st;
    logic [4:0] mask = 5'((1 << aw) - 1);
    int pos[8] = '{0, 2, 3, 4, 5, 6, 7, 8};
    d = '0;
    d.pc = pc;
    d.f3 = f3;
    if (ld | opi | jalr) d.imm = 32'($signed(ins[31:20]));
    else if (lui | auipc) d.imm = ins & 32'hFFFF_F000;
    else if (jal) d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    else if (br) d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    else if (st) d.imm = 32'($signed({ins[31:25], ins[11:7]}));
    d.rd  = urd  ? (ins[11:7] & mask)  : 5'd0;
    d.rs1 = urs1 ? (ins[19:15] & mask) : 5'd0;
    d.rs2 = urs2 ? (ins[24:20] & mask) : 5'd0;
    d.csr = sys ? ins[31:20] : 12'd0;
    d.s1  = (auipc | jal | jalr) ? 2'b10 : 2'b01;
    d.s2  = (opr | br | (sys && f3 == 3'd2)) ? 3'b001 : (jal | jalr) ? 3'b100 : 3'b010;
    if (ld | st | lui | auipc | jal | jalr) d.alu = 10'd1;
    else if (opr | opi) begin
      d.alu = 10'(1 << pos[f3]);
      if (opr && f3 == 3'd0 && f7[5]) d.alu = 10'd2;
      if (f3 == 3'd5 && f7[5]) d.alu = 10'd512;
    end else if (br) begin
      if (f3 <= 3'd1) d.alu = 10'd2;
      else if (f3 == 3'd4 || f3 == 3'd5) d.alu = 10'd8;
      else if (f3 >= 3'd6) d.alu = 10'd16;
    end else if (sys) begin
      if (f3 == 3'd1) d.alu = 10'd1;
      if (f3 == 3'd2) d.alu = 10'd128;
    end
    d.ctrl = {sys && f3 != 0, !(st | br | fen), em && opr && f7 == 7'd1, fen && f3 == 3'd1,
              sys && f3 == 0 && ins[21:20] == 2'd2, sys && f3 == 0 && ins[21:20] == 2'd1,
              sys && f3 == 0 && ins[21:20] == 2'd0, jalr, jal, br, st, ld};
    d.ill = !(lui | auipc | jal | jalr | br | ld | st | opi | opr | fen | sys) ||
            (opr && !(f7 == 7'd0 || f7 == 7'h20 || (em && f7 == 7'd1))) ||
            (aw == 4 && ((urd && ins[11]) || (urs1 && ins[19]) || (urs2 && ins[24])));
    if (d.ill) begin
      d.ctrl = '0;
      d.alu  = '0;
    end
    return d;
  endfunction

  task automatic cmp_entry(input string p, input exp_t o, input exp_t d);
    check_eq({p, "_pc"}, o.pc, d.pc);
    check_eq({p, "_imm"}, o.imm, d.imm);
    check_eq({p, "_rd"}, 32'(o.rd), 32'(d.rd));
    check_eq({p, "_rs1"}, 32'(o.rs1), 32'(d.rs1));
    check_eq({p, "_rs2"}, 32'(o.rs2), 32'(d.rs2));
    check_eq({p, "_csr"}, 32'(o.csr), 32'(d.csr));
    check_eq({p, "_exu_opt"}, 32'(o.f3), 32'(d.f3));
    check_eq({p, "_alu"}, 32'(o.alu), 32'(d.alu));
    check_eq({p, "_sel1"}, 32'(o.s1), 32'(d.s1));
    check_eq({p, "_sel2"}, 32'(o.s2), 32'(d.s2));
    check_eq({p, "_ctrl"}, 32'(o.ctrl), 32'(d.ctrl));
    check_eq({p, "_illegal"}, 32'(o.ill), 32'(d.ill));
  endtask

  task automatic check_outputs();
    exp_t o;
    check_eq("e_out_valid", 32'(e_out_valid), 32'(q.size() != 0));
    check_eq("i_out_valid", 32'(i_out_valid), 32'(q.size() != 0));
    check_eq("e_in_ready", 32'(e_in_ready), 32'(q.size() < 2));
    check_eq("i_in_ready", 32'(i_in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      o = '{e_pc, e_imm, {1'b0, e_rd}, {1'b0, e_rs1}, {1'b0, e_rs2}, e_csr, e_f3, e_alu, e_s1,
            e_s2, e_ctrl, e_illegal};
      cmp_entry("e", o, model_dec(q[0].ins, q[0].pc, 4, 1'b0));
      o = '{i_pc, i_imm, i_rd, i_rs1, i_rs2, i_csr, i_f3, i_alu, i_s1, i_s2, i_ctrl, i_illegal};
      cmp_entry("i", o, model_dec(q[0].ins, q[0].pc, 5, 1'b1));
    end
  endtask

  // Drive one cycle's inputs, advance the model across the coming edge, then check.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit acc, drn;
    in_valid  = v;
    in_ins    = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2) && !fl;
    drn = (q.size() != 0) && ordy;
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    @(negedge clock);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0] ops[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                            7'h0f, 7'h73};
    logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
    logic [31:0] w = $urandom;
    if ($urandom_range(7) != 0) w[6:0] = ops[$urandom_range(10)];
    if ($urandom_range(3) != 0) w[31:25] = f7s[$urandom_range(2)];
    if ($urandom_range(1) != 0) begin
      w[11] = 1'b0;
      w[19] = 1'b0;
      w[24] = 1'b0;
    end
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_ins = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #2;
    check_eq("rst_out_valid", 32'(e_out_valid | i_out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(e_in_ready & i_in_ready), 32'd1);
    check_eq("rst_pc", i_pc | e_pc, 32'd0);
    check_eq("rst_ctrl_alu", {10'd0, i_alu, i_ctrl} | {10'd0, e_alu, e_ctrl}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    cycle(1, 32'hFFF1_0093, 32'h100, 1, 0);
    check_eq("addi_imm", i_imm, 32'hFFFF_FFFF);
    check_eq("addi_rd_rs", {i_rd, i_rs1, i_rs2}, {5'd1, 5'd2, 5'd0});
    check_eq("addi_alu", 32'(i_alu), 32'd1);
    check_eq("addi_sel2_wen", {i_s2, i_ctrl[10]}, {3'b010, 1'b1});
    cycle(1, 32'h4052_51B3, 32'h104, 1, 0);
    check_eq("sra_alu", 32'(i_alu), 32'd512);
    check_eq("sra_rs2_sel2", {i_rs2, i_s2}, {5'd5, 3'b001});
    cycle(1, 32'h0052_51B3, 32'h108, 1, 0);
    check_eq("srl_alu", 32'(i_alu), 32'd64);
    cycle(1, 32'h0000_0833, 32'h10C, 1, 0);
    check_eq("rv32e_rd16_ill", {e_illegal, e_ctrl, e_alu}, 32'h0040_0000);
    check_eq("rv32i_rd16", {i_illegal, i_rd}, {1'b0, 5'd16});
    cycle(1, 32'h0231_00B3, 32'h110, 1, 0);
    check_eq("mul_no_m_ill", 32'(e_illegal), 32'd1);
    check_eq("mul_m", {i_illegal, i_ctrl[9], i_f3}, {1'b0, 1'b1, 3'd0});
    cycle(0, 0, 0, 1, 0);

    // Backpressure: A held, B in skid, C waits, then A/B/C drain on consecutive cycles.
    cycle(1, 32'h0010_0093, 32'hA0, 0, 0);
    cycle(1, 32'h0020_0113, 32'hB0, 0, 0);
    check_eq("bp_ready_low", 32'(i_in_ready | e_in_ready), 32'd0);
    cycle(1, 32'h0030_0193, 32'hC0, 0, 0);
    check_eq("bp_hold_a", i_pc, 32'hA0);
    cycle(1, 32'h0030_0193, 32'hC0, 1, 0);
    check_eq("bp_b", i_pc, 32'hB0);
    cycle(1, 32'h0030_0193, 32'hC0, 1, 0);
    check_eq("bp_c", i_pc, 32'hC0);
    cycle(0, 0, 0, 1, 0);

    // Flush with both entries full and a word presented.
    cycle(1, 32'h0010_0093, 32'h200, 0, 0);
    cycle(1, 32'h0020_0113, 32'h204, 0, 0);
    cycle(1, 32'h0030_0193, 32'h208, 0, 1);
    check_eq("flush_state", {e_out_valid, i_out_valid, e_in_ready, i_in_ready}, 32'b0011);
    cycle(0, 0, 0, 1, 0);
    check_eq("flush_dropped", 32'(i_out_valid), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(3) != 0, rand_ins(), $urandom, $urandom_range(9) < 7,
            $urandom_range(31) == 0);
    end

    // Asynchronous reset away from any clock edge.
    cycle(1, 32'h0010_0093, 32'h300, 0, 0);
    cycle(1, 32'h0020_0113, 32'h304, 0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(e_out_valid | i_out_valid), 32'd0);
    check_eq("arst_ready", 32'(e_in_ready & i_in_ready), 32'd1);
    check_eq("arst_data", i_pc | i_imm | e_pc | e_imm, 32'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cycle($urandom_range(3) != 0, rand_ins(), $urandom, $urandom_range(1) != 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
